// File: rtl/stdp_timing_tracker.sv
// stdp_timing_tracker
// Tracks the most recent pre- and postsynaptic spike timesteps and turns each
// spike pairing into one timing event: t_change = delta_steps * DT (Qn.Q,
// saturated to the largest positive value), with ltp selecting the
// potentiation (post after pre) or depression (pre after post) branch.
// Events are handed out through a valid/ready port. An event that arrives
// while the previous one is still being computed or held is discarded and
// recorded in the sticky dropped flag.
// Optional feature: define STDP_WINDOW_EN to silently suppress events whose
// timestep distance exceeds WINDOW.
module stdp_timing_tracker #(
  parameter int              N      = 32,
  parameter int              Q      = 16,
  parameter int              CNT_W  = 16,
  parameter logic [N-1:0]    DT     = 32'h0000_1000,
  parameter int unsigned     WINDOW = 16'd256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         pre_spike,
  input  logic         post_spike,
  output logic [N-1:0] t_change,
  output logic         ltp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         dropped
);

  localparam int          PROD_W = CNT_W + N;
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};

  // Parameter sanity: the fraction must fit in the word and the window must
  // be expressible as a timestep distance.
  if (Q >= N || (64'(WINDOW) >> CNT_W) != 64'd0) begin : g_bad_params
    $error("stdp_timing_tracker: Q must be < N and WINDOW must fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   now;
  logic [CNT_W-1:0]   last_pre;
  logic [CNT_W-1:0]   last_post;
  logic               pre_seen;
  logic               post_seen;
  logic [CNT_W-1:0]   delta_q;
  logic               kind_q;

  logic               ev;
  logic               ev_ltp;
  logic [CNT_W-1:0]   ev_delta;
  logic               ev_ok;
  logic [PROD_W-1:0]  prod;
  logic [N-1:0]       scaled;

  // Classify the current timestep's spikes into at most one event.
  always_comb begin
    ev       = 1'b0;
    ev_ltp   = 1'b0;
    ev_delta = '0;
    if (tick) begin
      if (post_spike && (pre_seen || pre_spike)) begin
        // A coincident pre/post pair with no earlier pre counts as zero delay.
        ev       = 1'b1;
        ev_ltp   = 1'b1;
        ev_delta = pre_seen ? (now - last_pre) : '0;
      end else if (pre_spike && !post_spike && post_seen) begin
        ev       = 1'b1;
        ev_delta = now - last_post;
      end
    end
  end

`ifdef STDP_WINDOW_EN
  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
  // Only pairings close enough in time are allowed to reach the FSM.
  always_comb begin
    ev_ok = ev && (ev_delta <= WINDOW_C);
  end
`else
  // Every pairing is forwarded regardless of distance.
  always_comb begin
    ev_ok = ev;
  end
`endif

  // Full-width delta*DT with clamp to the largest positive Qn.Q value.
  always_comb begin
    prod   = PROD_W'(delta_q) * PROD_W'(DT);
    scaled = (|prod[PROD_W-1:N-1]) ? SAT_MAX : prod[N-1:0];
  end

  // Timestep counter and last-spike timestamps; updated on every tick even
  // when the resulting event is discarded or suppressed.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let last_pre update
    // before the delta that depends on it is computed elsewhere.
    if (rst) begin
      now       <= '0;
      last_pre  <= '0;
      last_post <= '0;
      pre_seen  <= 1'b0;
      post_seen <= 1'b0;
    end else if (tick) begin
      now <= now + 1'b1;
      if (pre_spike) begin
        last_pre <= now;
        pre_seen <= 1'b1;
      end
      if (post_spike) begin
        last_post <= now;
        post_seen <= 1'b1;
      end
    end
  end

  // Event FSM: latch in IDLE, scale in CALC, present in HOLD until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      delta_q   <= '0;
      kind_q    <= 1'b0;
      t_change  <= '0;
      ltp       <= 1'b0;
      out_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      // Busy covers CALC and all of HOLD, including its handshake cycle.
      if (ev_ok && state != IDLE) begin
        dropped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ev_ok) begin
            delta_q <= ev_delta;
            kind_q  <= ev_ltp;
            state   <= CALC;
          end
        end
        CALC: begin
          t_change  <= scaled;
          ltp       <= kind_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
